// File: rtl/channel_initiator.sv
// Channel-side initiator: selects a CU, issues one command, then moves data over the bus-and-tag channel.
// Optional watchdog on tag responses is enabled with the CHANNEL_TIMEOUT_EN macro.
module channel_initiator #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  dev_address,
    input  logic [7:0]  cmd,
    input  logic [15:0] byte_count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [7:0]  status,
    output logic [15:0] xfer_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic        operational_out,
    output logic        address_out,
    output logic        command_out,
    output logic        service_out,
    output logic        select_out,
    output logic        hold_out,
    output logic        suppress_out,
    input  logic        operational_in,
    input  logic        address_in,
    input  logic        status_in,
    input  logic        service_in,
    input  logic        request_in,
    input  logic        select_in
);
    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_ADDR, S_CMD, S_ISTAT, S_ISTAT_ACK, S_DATA,
        S_DACK, S_STOP, S_ESTAT, S_ESTAT_ACK, S_ABORT, S_FIN
    } state_t;

    state_t      state_q;
    logic [7:0]  dev_q;
    logic [7:0]  cmd_q;
    logic [15:0] bcnt_q;
    logic        is_read;
    logic        is_rw;
    logic        op_lost;
    logic        wd_expired;
    logic [15:0] xfer_inc;
    logic        unused_inputs;

    assign is_read       = (cmd_q == 8'h02);
    assign is_rw         = (cmd_q == 8'h01) || is_read;
    assign xfer_inc      = (xfer_count == 16'hFFFF) ? xfer_count : xfer_count + 16'd1;
    assign suppress_out  = 1'b0;
    assign unused_inputs = ^{request_in, select_in};

    // Once the CU has answered selection, losing operational_in is a protocol violation.
    assign op_lost = !operational_in &&
                     (state_q inside {S_ADDR, S_CMD, S_ISTAT, S_ISTAT_ACK, S_DATA,
                                      S_DACK, S_STOP, S_ESTAT, S_ESTAT_ACK});

`ifdef CHANNEL_TIMEOUT_EN
    state_t      last_q;
    logic [15:0] wdog_q;

    // The count is stale on the first cycle of a new state, so expiry is gated until it settles.
    assign wd_expired = (state_q == last_q) && (wdog_q >= TIMEOUT_CYCLES) &&
                        (state_q != S_IDLE) && (state_q != S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= S_IDLE;
            wdog_q <= 16'd0;
        end else begin
            last_q <= state_q;
            if (state_q != last_q)
                wdog_q <= 16'd1;
            else if (wdog_q != 16'hFFFF)
                wdog_q <= wdog_q + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            dev_q           <= 8'd0;
            cmd_q           <= 8'd0;
            bcnt_q          <= 16'd0;
            wr_ready        <= 1'b0;
            rd_data         <= 8'd0;
            rd_valid        <= 1'b0;
            status          <= 8'd0;
            xfer_count      <= 16'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            bus_out         <= 8'd0;
            operational_out <= 1'b0;
            address_out     <= 1'b0;
            command_out     <= 1'b0;
            service_out     <= 1'b0;
            select_out      <= 1'b0;
            hold_out        <= 1'b0;
        end else begin
            operational_out <= 1'b1;
            wr_ready        <= 1'b0;
            rd_valid        <= 1'b0;
            done            <= 1'b0;
            if (wd_expired) begin
                if (state_q == S_ABORT) begin
                    state_q <= S_FIN;
                end else begin
                    error       <= 1'b1;
                    address_out <= 1'b0;
                    command_out <= 1'b0;
                    service_out <= 1'b0;
                    select_out  <= 1'b0;
                    hold_out    <= 1'b0;
                    state_q     <= S_ABORT;
                end
            end else if (op_lost) begin
                error   <= 1'b1;
                state_q <= S_FIN;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        dev_q       <= dev_address;
                        cmd_q       <= cmd;
                        bcnt_q      <= byte_count;
                        xfer_count  <= 16'd0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        bus_out     <= dev_address;
                        address_out <= 1'b1;
                        select_out  <= 1'b1;
                        hold_out    <= 1'b1;
                        state_q     <= S_SEL;
                    end
                    S_SEL: if (operational_in) begin
                        address_out <= 1'b0;
                        state_q     <= S_ADDR;
                    end
                    S_ADDR: if (address_in) begin
                        if (bus_in != dev_q) begin
                            error       <= 1'b1;
                            command_out <= 1'b0;
                            service_out <= 1'b0;
                            select_out  <= 1'b0;
                            hold_out    <= 1'b0;
                            state_q     <= S_ABORT;
                        end else begin
                            bus_out     <= cmd_q;
                            command_out <= 1'b1;
                            state_q     <= S_CMD;
                        end
                    end
                    S_CMD: if (!address_in) begin
                        command_out <= 1'b0;
                        state_q     <= S_ISTAT;
                    end
                    S_ISTAT: if (status_in) begin
                        status      <= bus_in;
                        service_out <= 1'b1;
                        state_q     <= S_ISTAT_ACK;
                    end
                    S_ISTAT_ACK: if (!status_in) begin
                        service_out <= 1'b0;
                        // CU busy, or channel-end plus device-end already, means no data phase.
                        if (status[3] || (status[5:4] == 2'b11))
                            state_q <= S_FIN;
                        else if (is_rw)
                            state_q <= S_DATA;
                        else
                            state_q <= S_ESTAT;
                    end
                    S_DATA: begin
                        if (status_in) begin
                            if (service_in)
                                error <= 1'b1;
                            state_q <= S_ESTAT;
                        end else if (service_in) begin
                            if (xfer_count == bcnt_q) begin
                                command_out <= 1'b1;
                                state_q     <= S_STOP;
                            end else if (is_read) begin
                                rd_data     <= bus_in;
                                rd_valid    <= 1'b1;
                                xfer_count  <= xfer_inc;
                                service_out <= 1'b1;
                                state_q     <= S_DACK;
                            end else if (wr_valid) begin
                                bus_out     <= wr_data;
                                wr_ready    <= 1'b1;
                                xfer_count  <= xfer_inc;
                                service_out <= 1'b1;
                                state_q     <= S_DACK;
                            end
                        end
                    end
                    S_DACK: if (!service_in) begin
                        service_out <= 1'b0;
                        state_q     <= S_DATA;
                    end
                    S_STOP: if (!service_in) begin
                        command_out <= 1'b0;
                        state_q     <= S_ESTAT;
                    end
                    S_ESTAT: if (status_in) begin
                        status      <= bus_in;
                        service_out <= 1'b1;
                        state_q     <= S_ESTAT_ACK;
                    end
                    S_ESTAT_ACK: if (!status_in) begin
                        service_out <= 1'b0;
                        state_q     <= S_FIN;
                    end
                    S_ABORT: begin
                        address_out <= 1'b0;
                        command_out <= 1'b0;
                        service_out <= 1'b0;
                        select_out  <= 1'b0;
                        hold_out    <= 1'b0;
                        if (!operational_in)
                            state_q <= S_FIN;
                    end
                    S_FIN: begin
                        address_out <= 1'b0;
                        command_out <= 1'b0;
                        service_out <= 1'b0;
                        select_out  <= 1'b0;
                        hold_out    <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_channel_initiator.sv
// Bench for channel_initiator: a behavioural mock CU answers the tags while a host model drives start and byte streams.
`timescale 1ns/1ps
module tb_channel_initiator;
    localparam int T_SELADDR = 0, T_ADDR = 1, T_CMD = 2, T_SRV = 3, T_SRV_OR_CMD = 4, T_SEL = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  dev_address = 8'd0, cmd = 8'd0, wr_data = 8'd0, bus_in = 8'd0;
    logic [15:0] byte_count = 16'd0;
    logic        wr_valid = 1'b0;
    logic        operational_in = 1'b0, address_in = 1'b0, status_in = 1'b0, service_in = 1'b0;
    logic        request_in = 1'b0, select_in = 1'b0;
    logic        wr_ready, rd_valid, busy, done, error;
    logic [7:0]  rd_data, status, bus_out;
    logic [15:0] xfer_count;
    logic        operational_out, address_out, command_out, service_out, select_out, hold_out, suppress_out;

    always #5 clk = ~clk;

    channel_initiator #(.TIMEOUT_CYCLES(16'd50)) dut (
        .clk(clk), .reset(reset), .start(start), .dev_address(dev_address), .cmd(cmd),
        .byte_count(byte_count), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .status(status), .xfer_count(xfer_count),
        .busy(busy), .done(done), .error(error), .bus_out(bus_out), .bus_in(bus_in),
        .operational_out(operational_out), .address_out(address_out), .command_out(command_out),
        .service_out(service_out), .select_out(select_out), .hold_out(hold_out),
        .suppress_out(suppress_out), .operational_in(operational_in), .address_in(address_in),
        .status_in(status_in), .service_in(service_in), .request_in(request_in), .select_in(select_in)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_got[$];
    int wr_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (rd_valid) rd_got.push_back(rd_data);
        if (wr_ready) wr_cnt++;
        if (done) done_cnt++;
    end

    // Mock CU configuration and observations
    logic [7:0] cu_echo, cu_istat, cu_estat, cu_cmd;
    int         cu_limit;
    bit         cu_stop_at_data = 1'b0;
    bit         cu_stop_seen;
    int         cu_wait1;
    logic [7:0] cu_rd_q[$];
    logic [7:0] cu_wr_got[$];
    logic [7:0] host_wr_q[$];

    function automatic logic tag_val(input int w);
        case (w)
            T_SELADDR:    tag_val = select_out & address_out;
            T_ADDR:       tag_val = address_out;
            T_CMD:        tag_val = command_out;
            T_SRV:        tag_val = service_out;
            T_SRV_OR_CMD: tag_val = service_out | command_out;
            default:      tag_val = select_out;
        endcase
    endfunction

    task automatic wait_tag(input int w, input logic v, input string nm, output int cyc);
        cyc = 0;
        while (tag_val(w) !== v && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (tag_val(w) !== v) begin
            checks++; errors++;
            $display("FAIL wait_%s: tag %b after %0d cycles, expected %b", nm, tag_val(w), cyc, v);
        end
    endtask

    task automatic cu_run();
        int c, i;
        bit stopped, has_end;
        logic [7:0] addr_seen;
        wait_tag(T_SELADDR, 1'b1, "select", c);
        addr_seen = bus_out;
        operational_in = 1'b1;
        wait_tag(T_ADDR, 1'b0, "address_drop", c);
        bus_in = cu_echo;
        address_in = 1'b1;
        if (cu_echo != addr_seen) begin
            wait_tag(T_SEL, 1'b0, "abort_select_drop", c);
            address_in = 1'b0; operational_in = 1'b0; bus_in = 8'd0;
            return;
        end
        wait_tag(T_CMD, 1'b1, "command", c);
        cu_cmd = bus_out;
        address_in = 1'b0;
        wait_tag(T_CMD, 1'b0, "command_drop", c);
        bus_in = cu_istat;
        status_in = 1'b1;
        wait_tag(T_SRV, 1'b1, "istat_service", c);
        status_in = 1'b0;
        wait_tag(T_SRV, 1'b0, "istat_service_drop", c);
        if (cu_stop_at_data) return;
        has_end = !(cu_istat[3] || cu_istat[5:4] == 2'b11);
        if (has_end && (cu_cmd == 8'h01 || cu_cmd == 8'h02)) begin
            i = 0; stopped = 1'b0;
            while (!stopped && i < cu_limit) begin
                bus_in = (cu_cmd == 8'h02) ? cu_rd_q[i] : 8'h00;
                service_in = 1'b1;
                wait_tag(T_SRV_OR_CMD, 1'b1, "data_response", c);
                if (i == 1) cu_wait1 = c;
                if (command_out) begin
                    stopped = 1'b1; cu_stop_seen = 1'b1;
                    service_in = 1'b0;
                    wait_tag(T_CMD, 1'b0, "stop_drop", c);
                end else begin
                    if (cu_cmd == 8'h01) cu_wr_got.push_back(bus_out);
                    service_in = 1'b0;
                    wait_tag(T_SRV, 1'b0, "data_service_drop", c);
                end
                i++;
            end
        end
        if (has_end) begin
            bus_in = cu_estat;
            status_in = 1'b1;
            wait_tag(T_SRV, 1'b1, "estat_service", c);
            status_in = 1'b0;
            wait_tag(T_SRV, 1'b0, "estat_service_drop", c);
        end
        bus_in = 8'd0;
        wait_tag(T_SEL, 1'b0, "final_select_drop", c);
        operational_in = 1'b0;
    endtask

    // One operation against the mock CU; expectations come from the channel rules, not the RTL.
    task automatic test_transfer(input string nm, input logic [7:0] dev, input logic [7:0] echo,
                                 input logic [7:0] c, input logic [15:0] bc, input logic [7:0] istat,
                                 input logic [7:0] estat, input int limit, input int gap);
        int rb, w0, d0, nexp;
        bit mism, ended, dphase, stop_exp;
        logic [7:0] st_before, exp_status;
        mism     = (echo != dev);
        ended    = !(istat[3] || istat[5:4] == 2'b11);
        dphase   = !mism && ended && (c == 8'h01 || c == 8'h02);
        nexp     = dphase ? ((int'(bc) < limit) ? int'(bc) : limit) : 0;
        stop_exp = dphase && (int'(bc) < limit);
        cu_echo = echo; cu_istat = istat; cu_estat = estat; cu_limit = limit;
        cu_stop_seen = 1'b0; cu_wait1 = 0; cu_cmd = 8'hxx;
        cu_wr_got.delete();
        rb = rd_got.size(); w0 = wr_cnt; d0 = done_cnt; st_before = status;
        fork
            begin
                @(negedge clk);
                dev_address = dev; cmd = c; byte_count = bc; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                fork
                    begin
                        if (dphase && c == 8'h01) begin
                            for (int i = 0; i < nexp; i++) begin
                                int cnt0;
                                if (i == 1 && gap > 0) begin
                                    wr_valid = 1'b0;
                                    repeat (gap) @(negedge clk);
                                end
                                wr_data = host_wr_q[i]; wr_valid = 1'b1; cnt0 = wr_cnt;
                                for (int k = 0; k < 2000 && wr_cnt == cnt0 && done_cnt == d0; k++) @(negedge clk);
                                if (done_cnt != d0) break;
                            end
                            wr_valid = 1'b0;
                        end
                    end
                    begin
                        for (int k = 0; k < 4000 && done_cnt == d0; k++) @(negedge clk);
                    end
                join
            end
            begin
                cu_run();
            end
        join
        repeat (2) @(negedge clk);
        exp_status = mism ? st_before : (ended ? estat : istat);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s done_pulses: got %0d, expected 1", nm, done_cnt - d0); end
        checks++; if (error !== mism) begin errors++; $display("FAIL %s error: got %b, expected %b", nm, error, mism); end
        checks++; if (xfer_count !== 16'(nexp)) begin errors++; $display("FAIL %s xfer_count: got %0d, expected %0d", nm, xfer_count, nexp); end
        checks++; if (status !== exp_status) begin errors++; $display("FAIL %s status: got %h, expected %h", nm, status, exp_status); end
        checks++; if ({busy, select_out, hold_out, service_out, command_out} !== 5'b0) begin
            errors++; $display("FAIL %s idle_tags: got %b, expected 00000", nm, {busy, select_out, hold_out, service_out, command_out}); end
        checks++; if (cu_stop_seen !== stop_exp) begin errors++; $display("FAIL %s channel_stop: got %b, expected %b", nm, cu_stop_seen, stop_exp); end
        if (!mism) begin
            checks++; if (cu_cmd !== c) begin errors++; $display("FAIL %s cu_command: got %h, expected %h", nm, cu_cmd, c); end
        end
        checks++;
        if (rd_got.size() - rb !== ((c == 8'h02) ? nexp : 0)) begin
            errors++; $display("FAIL %s rd_valid_pulses: got %0d, expected %0d", nm, rd_got.size() - rb, (c == 8'h02) ? nexp : 0);
        end else if (c == 8'h02) begin
            for (int i = 0; i < nexp; i++) begin
                checks++;
                if (rd_got[rb + i] !== cu_rd_q[i]) begin errors++; $display("FAIL %s rd_data[%0d]: got %h, expected %h", nm, i, rd_got[rb + i], cu_rd_q[i]); end
            end
        end
        checks++;
        if (wr_cnt - w0 !== ((c == 8'h01) ? nexp : 0) || cu_wr_got.size() != ((c == 8'h01) ? nexp : 0)) begin
            errors++; $display("FAIL %s write_count: wr_ready %0d cu_got %0d, expected %0d", nm, wr_cnt - w0, cu_wr_got.size(), (c == 8'h01) ? nexp : 0);
        end else if (c == 8'h01) begin
            for (int i = 0; i < nexp; i++) begin
                checks++;
                if (cu_wr_got[i] !== host_wr_q[i]) begin errors++; $display("FAIL %s cu_wr_data[%0d]: got %h, expected %h", nm, i, cu_wr_got[i], host_wr_q[i]); end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_ready, rd_data, rd_valid, status, xfer_count, busy, done, error, bus_out, operational_out,
             address_out, command_out, service_out, select_out, hold_out, suppress_out} !== 52'd0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0 (busy=%b op=%b bus=%h)", busy, operational_out, bus_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (operational_out !== 1'b1) begin errors++; $display("FAIL reset_operational_out: got %b, expected 1", operational_out); end
        checks++; if (busy !== 1'b0 || suppress_out !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b suppress %b, expected 0 0", busy, suppress_out); end
    endtask

    task automatic test_nop();
        test_transfer("nop", 8'hFF, 8'hFF, 8'h03, 16'd4, 8'h30, 8'h00, 0, 0);
    endtask

    task automatic test_read_cu_end();
        cu_rd_q.delete();
        for (int i = 0; i < 8; i++) cu_rd_q.push_back(8'(i + 1));
        test_transfer("read_cu_end", 8'h40, 8'h40, 8'h02, 16'd8, 8'h00, 8'h30, 4, 0);
    endtask

    task automatic test_read_stop();
        cu_rd_q.delete();
        for (int i = 0; i < 8; i++) cu_rd_q.push_back(8'($urandom));
        test_transfer("read_stop", 8'h21, 8'h21, 8'h02, 16'd2, 8'h00, 8'h30, 8, 0);
    endtask

    task automatic test_write_stall();
        host_wr_q.delete();
        host_wr_q.push_back(8'hA5); host_wr_q.push_back(8'h5A); host_wr_q.push_back(8'hC3);
        test_transfer("write_stall", 8'h33, 8'h33, 8'h01, 16'd3, 8'h00, 8'h30, 3, 5);
        checks++; if (cu_wait1 < 4) begin errors++; $display("FAIL write_stall stall_cycles: got %0d, required at least 4", cu_wait1); end
    endtask

    task automatic test_busy_mismatch();
        test_transfer("cu_busy", 8'h10, 8'h10, 8'h02, 16'd4, 8'h08, 8'h30, 4, 0);
        test_transfer("addr_mismatch", 8'hFF, 8'h12, 8'h02, 16'd4, 8'h00, 8'h30, 4, 0);
    endtask

    task automatic test_zero_count();
        test_transfer("read_zero_count", 8'h05, 8'h05, 8'h02, 16'd0, 8'h00, 8'h30, 3, 0);
        test_transfer("write_zero_count", 8'h06, 8'h06, 8'h01, 16'd0, 8'h00, 8'h30, 2, 0);
        test_transfer("control_estat", 8'h07, 8'h07, 8'h04, 16'd1, 8'h00, 8'h0C, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] dev, c, istat;
            dev = 8'($urandom);
            c = 8'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: istat = 8'h08;
                1: istat = 8'h30;
                default: istat = 8'h00;
            endcase
            cu_rd_q.delete(); host_wr_q.delete();
            for (int i = 0; i < 8; i++) begin
                cu_rd_q.push_back(8'($urandom));
                host_wr_q.push_back(8'($urandom));
            end
            test_transfer($sformatf("random%0d", n), dev, ($urandom_range(0, 5) == 0) ? (dev ^ 8'h12) : dev,
                          c, 16'($urandom_range(0, 5)), istat, 8'($urandom), $urandom_range(1, 5), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_data();
        int d0;
        cu_echo = 8'h44; cu_istat = 8'h00; cu_stop_at_data = 1'b1; cu_limit = 4;
        d0 = done_cnt;
        @(negedge clk);
        dev_address = 8'h44; cmd = 8'h02; byte_count = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cu_run();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_data_busy: got %b, expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wr_ready, rd_data, rd_valid, status, xfer_count, busy, done, error, bus_out, operational_out,
             address_out, command_out, service_out, select_out, hold_out, suppress_out} !== 52'd0) begin
            errors++; $display("FAIL mid_data_reset_outputs: busy=%b select=%b op=%b status=%h, expected all 0", busy, select_out, operational_out, status);
        end
        @(negedge clk);
        operational_in = 1'b0; address_in = 1'b0; status_in = 1'b0; service_in = 1'b0; bus_in = 8'd0;
        cu_stop_at_data = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_data_no_done: got %0d pulses, expected 0", done_cnt - d0); end
        checks++; if (operational_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_data_recover: op %b busy %b, expected 1 0", operational_out, busy); end
    endtask

`ifdef CHANNEL_TIMEOUT_EN
    task automatic test_timeout();
        int d0, cyc;
        d0 = done_cnt;
        @(negedge clk);
        dev_address = 8'h55; cmd = 8'h02; byte_count = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin @(negedge clk); cyc++; end
        checks++; if (cyc < 40 || cyc > 80) begin errors++; $display("FAIL timeout_latency: got %0d cycles, expected 40..80", cyc); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b, expected 1", error); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nop();
        test_read_cu_end();
        test_read_stop();
        test_write_stall();
        test_busy_mismatch();
        test_zero_count();
        test_random();
        test_reset_mid_data();
`ifdef CHANNEL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/channel_initiator.md
Name: channel_initiator

Overview:
- Channel-side initiator for the bus-and-tag parallel channel. It is the end that selects a control unit, issues one command and moves data; the CU is the responder.
- A host-side start/done interface with byte streams drives the channel's outbound bus and tags, and samples the CU's inbound bus and tags.
- It sits in the bench and FPGA test top opposite mock CUs, and connects through the tee at the channel's "A" side.

Parameters:
- TIMEOUT_CYCLES, 16'd1000: tag-response watchdog limit in clk cycles. Used only with CHANNEL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts an operation; ignored unless idle
- dev_address  in  8  device address to select; sampled on start
- cmd  in  8  command byte; sampled on start; 01 WRITE, 02 READ, other values are treated as control
- byte_count  in  16  maximum data bytes; sampled on start
- wr_data  in  8  next byte to send
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  one-cycle pulse; current wr_data has been consumed
- rd_data  out  8  received byte
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- status  out  8  last status byte captured
- xfer_count  out  16  data bytes moved in this operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; operation finished
- error  out  1  sticky until next start; address mismatch, protocol violation or timeout
- bus_out  out  8  channel outbound bus
- bus_in  in  8  channel inbound bus
- operational_out, address_out, command_out, service_out, select_out, hold_out, suppress_out  out  1 each  outbound tags
- operational_in, address_in, status_in, service_in, request_in, select_in  in  1 each  inbound tags; request_in and select_in are unused

Behaviour:
- Reset values:
  - all outputs 0, including bus_out and every tag
  - state IDLE
  - suppress_out is held at 0 permanently.
- operational_out is 0 during reset and 1 from the first cycle after reset deasserts.
- All outputs are registered. A tag response appears 1 cycle after the inbound edge that causes it.
- bus_out always changes in the same cycle as the tag it qualifies, or earlier.
- States and transitions:
  - IDLE: on start, latch dev_address, cmd and byte_count; clear xfer_count and error; set busy. Drive bus_out=dev_address, address_out=1, select_out=1, hold_out=1. Go to SEL.
  - SEL: on operational_in=1, drop address_out. Go to ADDR.
  - ADDR: on address_in=1:
    - if bus_in != dev_address: set error, go to ABORT
    - else: drive bus_out=cmd, command_out=1, go to CMD.
  - CMD: on address_in=0, drop command_out. Go to ISTAT.
  - ISTAT: on status_in=1, latch status=bus_in, raise service_out. Go to ISTAT_ACK.
  - ISTAT_ACK: on status_in=0, drop service_out. Then:
    - if status[3] (BUSY) or status[5:4]==2'b11: go to FIN
    - else if cmd==01 or cmd==02: go to DATA
    - else: go to ESTAT.
  - DATA, evaluated on service_in=1, in this priority order:
    - xfer_count==byte_count: raise command_out (stop), go to STOP.
    - READ: rd_data=bus_in, rd_valid pulse, xfer_count+1, raise service_out, go to DACK.
    - WRITE with wr_valid=1: bus_out=wr_data, wr_ready pulse, xfer_count+1, raise service_out, go to DACK.
    - WRITE with wr_valid=0: stall in DATA, tags unchanged.
  - DATA, on status_in=1 instead: go to ESTAT. If status_in and service_in are both 1, status_in wins and error is set.
  - DACK: on service_in=0, drop service_out. Return to DATA.
  - STOP: on service_in=0, drop command_out. Go to ESTAT.
  - ESTAT: on status_in=1, latch status, raise service_out. Go to ESTAT_ACK.
  - ESTAT_ACK: on status_in=0, drop service_out. Go to FIN.
  - ABORT: drop every tag except operational_out. Wait for operational_in=0, then go to FIN.
  - FIN: drop select_out and hold_out, clear busy, pulse done. Go to IDLE.
- operational_in falling in any state other than IDLE, SEL or ABORT: set error, go to FIN.
- byte_count=0 with READ/WRITE: the first service_in is answered with stop, so xfer_count stays 0.
- xfer_count saturates at 16'hFFFF.
- Reset mid-operation: immediate return to reset values next cycle; no done pulse.

Optional Feature:
- Macro CHANNEL_TIMEOUT_EN.
- Enabled: a 16-bit watchdog clears on every state change. If it reaches TIMEOUT_CYCLES in any waiting state, set error, go to ABORT. ABORT itself is also bounded: on a second expiry, go straight to FIN.
- Disabled: no watchdog logic; waiting states wait forever.

Test Plan:
- NOP: cmd=03, address FF matches, CU status 0x30 -> initial status 0x30 captured, no data phase, done, error=0, xfer_count=0.
- READ, CU-ended: byte_count=8, CU limit 4 -> rd_data 01,02,03,04 each with an rd_valid pulse, ending status 0x30, xfer_count=4.
- READ, channel stop: byte_count=2, CU limit 8 -> 2 bytes, then command_out answers the 3rd service_in, CU ending status 0x30, xfer_count=2.
- WRITE: 3 bytes A5,5A,C3 with wr_valid deasserted for 5 cycles before byte 2, CU limit 3 -> CU receives all 3 in order, stall observed, 3 wr_ready pulses, ending status 0x30.
- Busy and mismatch:
  - CU busy: status 0x08 -> done after the initial status, no data phase.
  - CU echoes 0x12 for address FF: error=1, ABORT, then done.
- CHANNEL_TIMEOUT_EN, TIMEOUT_CYCLES=50, CU never raises operational_in -> error and done within about 50 cycles; reset mid-DATA returns all outputs to 0.
